// File: rtl/mem_wb_if.sv
// EX/MEM-to-MEM/WB bundle for the memory stage.
// Handshake: in_valid marks a real instruction in the EX/MEM slot; there is
// no ready signal. Backpressure is stall, and upstream must hold every in_*
// field stable while stall is high. out_valid marks a real instruction in the
// MEM/WB buffer.
interface mem_wb_if #(
  parameter int DATA_W = 16,
  parameter int RD_W   = 3
);
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_store_data;
  logic [RD_W-1:0]   in_rd;
  logic              in_valid;
  logic              in_mem_read;
  logic              in_mem_write;
  logic              in_mem_to_reg;
  logic              in_reg_write;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] out_buf3;
  logic [DATA_W-1:0] out_data_mem;
  logic              out_cntrl_wb_buf;
  logic [RD_W-1:0]   out_rd;
  logic              out_reg_write;
  logic              out_valid;

  modport master (
    output in_alu, in_store_data, in_rd, in_valid, in_mem_read, in_mem_write,
           in_mem_to_reg, in_reg_write, stall, flush,
    input  out_buf3, out_data_mem, out_cntrl_wb_buf, out_rd, out_reg_write,
           out_valid
  );

  modport slave (
    input  in_alu, in_store_data, in_rd, in_valid, in_mem_read, in_mem_write,
           in_mem_to_reg, in_reg_write, stall, flush,
    output out_buf3, out_data_mem, out_cntrl_wb_buf, out_rd, out_reg_write,
           out_valid
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage with the MEM/WB pipeline buffer folded in.
// Combinational read, synchronous write; the buffer captures the pre-edge
// memory word so a read+write to one address returns the old contents.
module mem_wb_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int RD_W   = 3
) (
  input logic     clk,
  input logic     rst,
  mem_wb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rd_word;
  logic              mem_we;

  logic [DATA_W-1:0] buf3_q;
  logic [DATA_W-1:0] data_mem_q;
  logic              cntrl_wb_q;
  logic [RD_W-1:0]   rd_q;
  logic              reg_write_q;
  logic              valid_q;

  // Word address is the low bits of the ALU result; upper bits alias.
  assign addr    = bus.in_alu[ADDR_W-1:0];
  assign rd_word = mem[addr];
  assign mem_we  = bus.in_valid & bus.in_mem_write & ~bus.stall & ~bus.flush;

  // Data memory: reset clears every word, otherwise one qualified write per edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[addr] <= bus.in_store_data;
    end
  end

  // MEM/WB buffer: reset > flush (bubble) > stall (hold) > load.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      buf3_q      <= '0;
      data_mem_q  <= '0;
      cntrl_wb_q  <= 1'b0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      valid_q     <= 1'b0;
    end else if (!bus.stall) begin
      buf3_q      <= bus.in_alu;
      data_mem_q  <= bus.in_mem_read ? rd_word : '0;
      cntrl_wb_q  <= bus.in_mem_to_reg & bus.in_valid;
      rd_q        <= bus.in_rd;
      reg_write_q <= bus.in_reg_write & bus.in_valid;
      valid_q     <= bus.in_valid;
    end
  end

  assign bus.out_buf3         = buf3_q;
  assign bus.out_data_mem     = data_mem_q;
  assign bus.out_cntrl_wb_buf = cntrl_wb_q;
  assign bus.out_rd           = rd_q;
  assign bus.out_reg_write    = reg_write_q;
  assign bus.out_valid        = valid_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, hand sequences for
// reset/flush interplay with stall, and a short randomised run.
module tb_mem_wb_stage;
  localparam int EW = 38;

  typedef struct packed {
    logic        rst, stall, flush, valid, mrd, mwr, m2r, rw;
    logic [15:0] alu, sd;
    logic [2:0]  rd;
    logic [EW-1:0] exp_out;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_wb_if #(.DATA_W(16), .RD_W(3)) bus ();
  mem_wb_stage #(.DATA_W(16), .ADDR_W(8), .RD_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_exp;
  logic [15:0]   model_mem [256];
  int n_checks = 0;
  int n_fail   = 0;
  int step     = 0;
  vec_t vecs [20];

  function automatic logic [EW-1:0] pk(logic [15:0] b3, logic [15:0] dm, logic cw,
                                       logic [2:0] rd, logic rw, logic v);
    return {v, rw, rd, cw, dm, b3};
  endfunction

  function automatic vec_t mk(logic r, logic st, logic fl, logic v, logic mrd,
                              logic mwr, logic m2r, logic rw, logic [15:0] alu,
                              logic [15:0] sd, logic [2:0] rd, logic [EW-1:0] e);
    vec_t t;
    t.rst = r; t.stall = st; t.flush = fl; t.valid = v; t.mrd = mrd; t.mwr = mwr;
    t.m2r = m2r; t.rw = rw; t.alu = alu; t.sd = sd; t.rd = rd; t.exp_out = e;
    return t;
  endfunction

  task automatic check_field(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h required %h", name, step, act, req);
    end
  endtask

  // Pop the oldest expectation and compare every buffer output against it.
  task automatic compare_out();
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard step %0d: got output with empty queue required entry", step);
      return;
    end
    e = exp_q.pop_front();
    check_field("out_buf3",         bus.out_buf3,                 e[15:0]);
    check_field("out_data_mem",     bus.out_data_mem,             e[31:16]);
    check_field("out_cntrl_wb_buf", {15'd0, bus.out_cntrl_wb_buf}, {15'd0, e[32]});
    check_field("out_rd",           {13'd0, bus.out_rd},           {13'd0, e[35:33]});
    check_field("out_reg_write",    {15'd0, bus.out_reg_write},    {15'd0, e[36]});
    check_field("out_valid",        {15'd0, bus.out_valid},        {15'd0, e[37]});
  endtask

  task automatic drive(input vec_t t);
    @(negedge clk);
    rst                = t.rst;
    bus.stall          = t.stall;
    bus.flush          = t.flush;
    bus.in_valid       = t.valid;
    bus.in_mem_read    = t.mrd;
    bus.in_mem_write   = t.mwr;
    bus.in_mem_to_reg  = t.m2r;
    bus.in_reg_write   = t.rw;
    bus.in_alu         = t.alu;
    bus.in_store_data  = t.sd;
    bus.in_rd          = t.rd;
    exp_q.push_back(t.exp_out);
    last_exp = t.exp_out;
    @(posedge clk);
    #1;
    compare_out();
    step++;
  endtask

  initial begin
    logic [EW-1:0] z;
    z = '0;
    rst = 1'b1;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_mem_read = 1'b0;
    bus.in_mem_write = 1'b0; bus.in_mem_to_reg = 1'b0; bus.in_reg_write = 1'b0;
    bus.in_alu = '0; bus.in_store_data = '0; bus.in_rd = '0;

    // rst st fl v mrd mwr m2r rw alu sd rd | expected {b3, dm, cw, rd, rw, v}
    vecs[0]  = mk(1, 0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  16'($urandom), 16'($urandom), 3'($urandom), z);
    vecs[1]  = mk(1, 1'($urandom), 1'($urandom), 1, 1'($urandom), 1, 1'($urandom), 1,
                  16'($urandom), 16'($urandom), 3'($urandom), z);
    vecs[2]  = mk(0, 0, 0, 1, 1, 0, 1, 1, 16'h000A, 16'h0000, 3'd2, pk(16'h000A, 16'h0000, 1, 3'd2, 1, 1));
    vecs[3]  = mk(0, 0, 0, 1, 0, 1, 0, 0, 16'h000A, 16'h3F21, 3'd0, pk(16'h000A, 16'h0000, 0, 3'd0, 0, 1));
    vecs[4]  = mk(0, 0, 0, 1, 1, 0, 1, 1, 16'h000A, 16'h0000, 3'd5, pk(16'h000A, 16'h3F21, 1, 3'd5, 1, 1));
    vecs[5]  = mk(0, 0, 0, 1, 0, 0, 0, 1, 16'h1234, 16'h0000, 3'd3, pk(16'h1234, 16'h0000, 0, 3'd3, 1, 1));
    vecs[6]  = mk(0, 0, 0, 1, 0, 0, 0, 1, 16'h4321, 16'h0000, 3'd6, pk(16'h4321, 16'h0000, 0, 3'd6, 1, 1));
    vecs[7]  = mk(0, 1, 0, 1, 1, 1, 0, 0, 16'h0020, 16'hBEEF, 3'd0, pk(16'h4321, 16'h0000, 0, 3'd6, 1, 1));
    vecs[8]  = mk(0, 1, 0, 1, 1, 1, 0, 0, 16'h0020, 16'hBEEF, 3'd0, pk(16'h4321, 16'h0000, 0, 3'd6, 1, 1));
    vecs[9]  = mk(0, 1, 0, 1, 1, 1, 0, 0, 16'h0020, 16'hBEEF, 3'd0, pk(16'h4321, 16'h0000, 0, 3'd6, 1, 1));
    vecs[10] = mk(0, 0, 0, 1, 1, 1, 0, 0, 16'h0020, 16'hBEEF, 3'd0, pk(16'h0020, 16'h0000, 0, 3'd0, 0, 1));
    vecs[11] = mk(0, 0, 0, 1, 1, 0, 1, 1, 16'h0020, 16'h0000, 3'd4, pk(16'h0020, 16'hBEEF, 1, 3'd4, 1, 1));
    vecs[12] = mk(0, 0, 1, 1, 0, 1, 0, 1, 16'h0030, 16'h5555, 3'd4, z);
    vecs[13] = mk(0, 0, 0, 0, 0, 1, 0, 1, 16'h0030, 16'h5555, 3'd4, pk(16'h0030, 16'h0000, 0, 3'd4, 0, 0));
    vecs[14] = mk(0, 0, 0, 1, 1, 0, 1, 1, 16'h0030, 16'h0000, 3'd1, pk(16'h0030, 16'h0000, 1, 3'd1, 1, 1));
    vecs[15] = mk(0, 0, 0, 1, 0, 1, 0, 0, 16'h0105, 16'hAAAA, 3'd0, pk(16'h0105, 16'h0000, 0, 3'd0, 0, 1));
    vecs[16] = mk(0, 0, 0, 1, 1, 0, 1, 1, 16'h0005, 16'h0000, 3'd2, pk(16'h0005, 16'hAAAA, 1, 3'd2, 1, 1));
    vecs[17] = mk(0, 0, 0, 1, 1, 1, 0, 0, 16'h0005, 16'h7777, 3'd0, pk(16'h0005, 16'hAAAA, 0, 3'd0, 0, 1));
    vecs[18] = mk(0, 0, 0, 1, 1, 0, 1, 1, 16'h0005, 16'h0000, 3'd3, pk(16'h0005, 16'h7777, 1, 3'd3, 1, 1));
    vecs[19] = mk(0, 0, 0, 0, 1, 0, 1, 1, 16'h0005, 16'h0000, 3'd7, pk(16'h0005, 16'h7777, 0, 3'd7, 0, 0));

    for (int i = 0; i < 20; i++) drive(vecs[i]);

    // Stall holds, then reset overrides stall+flush and clears memory.
    drive(mk(0, 1, 0, 1, 0, 1, 0, 1, 16'h0040, 16'h9999, 3'd1, pk(16'h0005, 16'h7777, 0, 3'd7, 0, 0)));
    drive(mk(1, 1, 1, 1, 0, 1, 0, 1, 16'h0040, 16'h9999, 3'd1, z));
    drive(mk(0, 0, 0, 1, 1, 0, 1, 1, 16'h000A, 16'h0000, 3'd5, pk(16'h000A, 16'h0000, 1, 3'd5, 1, 1)));
    drive(mk(0, 0, 0, 1, 1, 0, 1, 1, 16'h0005, 16'h0000, 3'd6, pk(16'h0005, 16'h0000, 1, 3'd6, 1, 1)));
    // Flush beats stall: bubble loads and the store is dropped.
    drive(mk(0, 1, 1, 1, 0, 1, 0, 1, 16'h0050, 16'h1357, 3'd2, z));
    drive(mk(0, 0, 0, 1, 1, 0, 0, 1, 16'h0050, 16'h0000, 3'd2, pk(16'h0050, 16'h0000, 0, 3'd2, 1, 1)));

    // Randomised run against a reference memory, starting from reset.
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 3'd0, z));
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    for (int n = 0; n < 80; n++) begin
      vec_t t;
      logic [7:0] a;
      logic [EW-1:0] e;
      a = 8'($urandom_range(0, 15) * 17);
      t = mk(0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), {8'($urandom), a}, 16'($urandom), 3'($urandom), z);
      if (t.flush) e = '0;
      else if (t.stall) e = last_exp;
      else e = pk(t.alu, t.mrd ? model_mem[a] : 16'h0000, t.m2r & t.valid, t.rd,
                  t.rw & t.valid, t.valid);
      t.exp_out = e;
      drive(t);
      if (t.valid && t.mwr && !t.stall && !t.flush) model_mem[a] = t.sd;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
